// File: rtl/add2_resp_chk.sv
// Response checker for the add2 circuit outputs (N50..N52): it compares captured and
// expected beats, counts mismatches and reports pass/fail. ADD2_RESP_CHK_MISR_EN adds a 3-bit MISR signature.
module add2_resp_chk #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pat,
  input  logic             resp_valid,
  input  logic [2:0]       resp,
  input  logic [2:0]       exp,
  output logic             resp_ready,
  output logic [CNT_W-1:0] pat_idx,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail,
  output logic             done,
`ifdef ADD2_RESP_CHK_MISR_EN
  output logic [2:0]       signature,
`endif
  output logic             pass
);

  localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_num_pat;
  logic [CNT_W-1:0] r_pat_idx;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [CNT_W-1:0] r_first_fail;
  logic             r_resp_ready;
  logic             r_done;
  logic             r_pass;

  logic             w_accept;
  logic             w_mismatch;
  logic [CNT_W-1:0] w_idx_inc;
  logic [CNT_W-1:0] w_fail_next;
  logic             w_last;

  // resp_ready is only high in RUN, so a beat offered at any other time is dropped
  assign w_accept    = resp_valid && r_resp_ready;
  assign w_mismatch  = (resp != exp);
  assign w_idx_inc   = r_pat_idx + CNT_W'(1);
  assign w_fail_next = (w_mismatch && (r_fail_cnt != ALL_ONES)) ? (r_fail_cnt + CNT_W'(1))
                                                                 : r_fail_cnt;
  assign w_last      = (w_idx_inc == r_num_pat);

`ifdef ADD2_RESP_CHK_MISR_EN
  logic [2:0] r_sig;
  logic [2:0] w_sig_next;

  // x^3+x+1 MISR folding one response vector per accepted beat
  assign w_sig_next = {r_sig[1] ^ resp[2],
                       r_sig[0] ^ r_sig[2] ^ resp[1],
                       r_sig[2] ^ resp[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= 3'b000;
    end else if ((r_state != RUN) && start) begin
      r_sig <= 3'b000;
    end else if ((r_state == RUN) && w_accept) begin
      r_sig <= w_sig_next;
    end
  end

  assign signature = r_sig;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_num_pat    <= '0;
      r_pat_idx    <= '0;
      r_fail_cnt   <= '0;
      r_first_fail <= ALL_ONES;
      r_resp_ready <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_num_pat    <= num_pat;
            r_pat_idx    <= '0;
            r_fail_cnt   <= '0;
            r_first_fail <= ALL_ONES;
            if (num_pat == '0) begin
              r_state      <= DONE;
              r_resp_ready <= 1'b0;
              r_done       <= 1'b1;
              r_pass       <= 1'b1;
            end else begin
              r_state      <= RUN;
              r_resp_ready <= 1'b1;
              r_done       <= 1'b0;
              r_pass       <= 1'b0;
            end
          end
        end
        RUN: begin
          if (w_accept) begin
            r_pat_idx  <= w_idx_inc;
            r_fail_cnt <= w_fail_next;
            // first_fail doubles as the "no failure yet" marker while fail_cnt is zero
            if (w_mismatch && (r_fail_cnt == '0)) begin
              r_first_fail <= r_pat_idx;
            end
            if (w_last) begin
              r_state      <= DONE;
              r_resp_ready <= 1'b0;
              r_done       <= 1'b1;
              r_pass       <= (w_fail_next == '0);
            end
          end
        end
        default: begin
          r_state      <= IDLE;
          r_resp_ready <= 1'b0;
          r_done       <= 1'b0;
          r_pass       <= 1'b0;
        end
      endcase
    end
  end

  assign resp_ready = r_resp_ready;
  assign pat_idx    = r_pat_idx;
  assign fail_cnt   = r_fail_cnt;
  assign first_fail = r_first_fail;
  assign done       = r_done;
  assign pass       = r_pass;

endmodule

// File: tb/tb_add2_resp_chk.sv
// Scoreboard bench for add2_resp_chk: directed runs push expected results, a monitor
// compares them when done rises. Define ADD2_RESP_CHK_MISR_EN to also cover the signature.
module tb_add2_resp_chk;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] num_pat = '0;
  logic       resp_valid = 1'b0;
  logic [2:0] resp = '0;
  logic [2:0] exp_v = '0;
  logic       resp_ready;
  logic [3:0] pat_idx;
  logic [3:0] fail_cnt;
  logic [3:0] first_fail;
  logic       done;
  logic       pass;
`ifdef ADD2_RESP_CHK_MISR_EN
  logic [2:0] signature;
`endif

  add2_resp_chk #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_pat    (num_pat),
    .resp_valid (resp_valid),
    .resp       (resp),
    .exp        (exp_v),
    .resp_ready (resp_ready),
    .pat_idx    (pat_idx),
    .fail_cnt   (fail_cnt),
    .first_fail (first_fail),
    .done       (done),
`ifdef ADD2_RESP_CHK_MISR_EN
    .signature  (signature),
`endif
    .pass       (pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pat;
    int fcnt;
    int ff;
    int ps;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: a rising done presents one run result
  logic done_prev = 1'b0;
  res_t mon_e;
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("run_pat_idx", 32'(pat_idx), 32'(mon_e.pat));
        chk("run_fail_cnt", 32'(fail_cnt), 32'(mon_e.fcnt));
        chk("run_first_fail", 32'(first_fail), 32'(mon_e.ff));
        chk("run_pass", 32'(pass), 32'(mon_e.ps));
        chk("run_resp_ready", 32'(resp_ready), 32'd0);
        $display("run done: pat_idx=%0d fail_cnt=%0d first_fail=%0h pass=%0b",
                 pat_idx, fail_cnt, first_fail, pass);
      end
    end
    done_prev = done;
  end

  task automatic push_exp(input int p, input int f, input int ff, input int ps);
    res_t e;
    e.pat = p; e.fcnt = f; e.ff = ff; e.ps = ps;
    sb.push_back(e);
  endtask

  task automatic start_run(input int n);
    @(negedge clk);
    start   = 1'b1;
    num_pat = 4'(n);
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic beat(input logic [2:0] r, input logic [2:0] e);
    int t = 0;
    resp_valid = 1'b1;
    resp       = r;
    exp_v      = e;
    while (!resp_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("beat_timeout", 32'(t), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("done_timeout", 32'(t), 32'd0);
    @(negedge clk);
  endtask

  task automatic run_vec(input int n, input logic [15:0] mis,
                         input int e_f, input int e_ff, input int e_ps);
    logic [2:0] r;
    push_exp(n, e_f, e_ff, e_ps);
    start_run(n);
    for (int i = 0; i < n; i++) begin
      r = 3'(i * 5 + 3);
      beat(r, mis[i] ? (r ^ 3'b100) : r);
    end
    resp_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_resp_ready", 32'(resp_ready), 32'd0);
    chk("rst_pat_idx", 32'(pat_idx), 32'd0);
    chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("rst_first_fail", 32'(first_fail), 32'hF);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
`ifdef ADD2_RESP_CHK_MISR_EN
    chk("rst_signature", 32'(signature), 32'd0);
`endif
    rst_n = 1'b1;

    // empty run straight to DONE
    push_exp(0, 0, 'hF, 1);
    start_run(0);
    chk("n0_done_next_cycle", 32'(done), 32'd1);
    wait_done();

    run_vec(6, 16'h0000, 0, 'hF, 1);
    run_vec(6, 16'h0014, 2, 2, 0);
    run_vec(15, 16'h7FFF, 15, 0, 0);

    // start during RUN ignored, valid held across the transition into DONE
    push_exp(6, 0, 'hF, 1);
    start_run(6);
    beat(3'b001, 3'b001);
    beat(3'b010, 3'b010);
    start   = 1'b1;
    num_pat = 4'd3;
    beat(3'b011, 3'b011);
    start   = 1'b0;
    num_pat = 4'd0;
    beat(3'b100, 3'b100);
    beat(3'b101, 3'b101);
    beat(3'b110, 3'b110);
    repeat (4) @(negedge clk);
    chk("held_pat_idx", 32'(pat_idx), 32'd6);
    chk("held_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("held_done", 32'(done), 32'd1);
    chk("held_resp_ready", 32'(resp_ready), 32'd0);
    resp_valid = 1'b0;

`ifdef ADD2_RESP_CHK_MISR_EN
    push_exp(2, 0, 'hF, 1);
    start_run(2);
    beat(3'b101, 3'b101);
    chk("misr_first", 32'(signature), 32'b101);
    beat(3'b011, 3'b011);
    resp_valid = 1'b0;
    wait_done();
    chk("misr_done", 32'(signature), 32'b010);
`endif

    // asynchronous reset mid-run
    start_run(6);
    beat(3'b001, 3'b001);
    beat(3'b010, 3'b011);
    beat(3'b011, 3'b011);
    resp_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_resp_ready", 32'(resp_ready), 32'd0);
    chk("mid_rst_pat_idx", 32'(pat_idx), 32'd0);
    chk("mid_rst_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("mid_rst_first_fail", 32'(first_fail), 32'hF);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_pass", 32'(pass), 32'd0);
`ifdef ADD2_RESP_CHK_MISR_EN
    chk("mid_rst_signature", 32'(signature), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    resp_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_start_pat_idx", 32'(pat_idx), 32'd0);
    chk("no_start_resp_ready", 32'(resp_ready), 32'd0);
    resp_valid = 1'b0;
    run_vec(6, 16'h0020, 1, 5, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
